// File: rtl/ref_point_buffer_pkg.sv
// Shared types and index-width helpers for the KNN reference-point buffer.
package knn_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      LOAD   = 2'd1,
      STREAM = 2'd2
   } state_e;

   // Smallest index width ever produced; a single-entry range still needs one bit.
   localparam int MIN_IDX_W = 1;

   // Index width able to address n entries, never narrower than MIN_IDX_W.
   function automatic int idx_w(input int n);
      return (n <= 2) ? MIN_IDX_W : $clog2(n);
   endfunction

endpackage

// File: rtl/ref_point_buffer_if.sv
// Handshake bus of the reference-point buffer. The optional vec_count output
// exists only when REFBUF_VEC_COUNT_EN is defined.
interface ref_point_buffer_if #(
   parameter int DATA_WIDTH = 32,
   parameter int NUM_REFS   = 4
);
   logic                           start;
   logic                           reload;
   logic                           s_valid;
   logic [DATA_WIDTH-1:0]          s_data;
   logic                           s_ready;
   logic                           m_valid;
   logic                           m_ready;
   logic [DATA_WIDTH-1:0]          m_data;
   logic [NUM_REFS*DATA_WIDTH-1:0] m_ref_data;
   logic                           m_last;
   logic                           loaded;
`ifdef REFBUF_VEC_COUNT_EN
   logic [31:0]                    vec_count;
`endif

   modport master (
      output start, reload, s_valid, s_data, m_ready,
      input  s_ready, m_valid, m_data, m_ref_data, m_last, loaded
`ifdef REFBUF_VEC_COUNT_EN
      , input vec_count
`endif
   );

   modport slave (
      input  start, reload, s_valid, s_data, m_ready,
      output s_ready, m_valid, m_data, m_ref_data, m_last, loaded
`ifdef REFBUF_VEC_COUNT_EN
      , output vec_count
`endif
   );
endinterface

// File: rtl/ref_point_buffer_ref_bank.sv
// One stored reference vector: synchronous write, combinational read,
// synchronous clear on rst.
module ref_bank #(
   parameter int DATA_WIDTH = 32,
   parameter int DIMENSIONS = 32,
   parameter int ADDR_W     = 5
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  we_i,
   input  logic [ADDR_W-1:0]     waddr_i,
   input  logic [DATA_WIDTH-1:0] wdata_i,
   input  logic [ADDR_W-1:0]     raddr_i,
   output logic [DATA_WIDTH-1:0] rdata_o
);
   logic [DATA_WIDTH-1:0] mem_q [DIMENSIONS];

   // Element storage: cleared on reset, written one element per load beat.
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < DIMENSIONS; i++) mem_q[i] <= '0;
      end else if (we_i) begin
         mem_q[waddr_i] <= wdata_i;
      end
   end

   assign rdata_o = mem_q[raddr_i];
endmodule

// File: rtl/ref_point_buffer.sv
// Reference-point buffer: loads NUM_REFS reference vectors, then streams data
// point elements paired with the matching element of every reference.
// Optional feature macro: REFBUF_VEC_COUNT_EN (adds vec_count output).
module ref_point_buffer
   import knn_pkg::*;
#(
   parameter int DATA_WIDTH = 32,
   parameter int DIMENSIONS = 32,
   parameter int NUM_REFS   = 4
) (
   input logic               clk,
   input logic               rst,
   ref_point_buffer_if.slave bus
);
   localparam int DIM_W = idx_w(DIMENSIONS);
   localparam int REF_W = idx_w(NUM_REFS);

   state_e                         state_q, state_d;
   logic [DIM_W-1:0]               dim_q, dim_d;
   logic [REF_W-1:0]               ref_q, ref_d;
   logic                           loaded_q, loaded_d;
   logic                           m_valid_q, m_valid_d;
   logic [DATA_WIDTH-1:0]          m_data_q, m_data_d;
   logic [NUM_REFS*DATA_WIDTH-1:0] m_ref_q, m_ref_d;
   logic                           m_last_q, m_last_d;
   logic [NUM_REFS*DATA_WIDTH-1:0] ref_rd;
   logic                           s_ready, load_acc, stream_acc, out_fire;
   logic                           last_dim, last_ref;

   assign last_dim = (dim_q == DIM_W'(DIMENSIONS - 1));
   assign last_ref = (ref_q == REF_W'(NUM_REFS - 1));
   assign out_fire = m_valid_q && bus.m_ready;

   for (genvar r = 0; r < NUM_REFS; r++) begin : g_bank
      ref_bank #(
         .DATA_WIDTH (DATA_WIDTH),
         .DIMENSIONS (DIMENSIONS),
         .ADDR_W     (DIM_W)
      ) u_bank (
         .clk     (clk),
         .rst     (rst),
         .we_i    (load_acc && (ref_q == REF_W'(r))),
         .waddr_i (dim_q),
         .wdata_i (bus.s_data),
         .raddr_i (dim_q),
         .rdata_o (ref_rd[r*DATA_WIDTH +: DATA_WIDTH])
      );
   end

   // Next-state, index and output-register logic; reload overrides the FSM last.
   always_comb begin
      state_d    = state_q;
      dim_d      = dim_q;
      ref_d      = ref_q;
      loaded_d   = loaded_q;
      m_valid_d  = m_valid_q;
      m_data_d   = m_data_q;
      m_ref_d    = m_ref_q;
      m_last_d   = m_last_q;
      s_ready    = 1'b0;
      load_acc   = 1'b0;
      stream_acc = 1'b0;
      case (state_q)
         IDLE: begin
            if (bus.start) state_d = loaded_q ? STREAM : LOAD;
         end
         LOAD: begin
            s_ready = !bus.reload;
            if (bus.s_valid && !bus.reload) begin
               load_acc = 1'b1;
               if (last_dim) begin
                  dim_d = '0;
                  if (last_ref) begin
                     loaded_d = 1'b1;
                     ref_d    = '0;
                     state_d  = STREAM;
                  end else begin
                     ref_d = ref_q + REF_W'(1);
                  end
               end else begin
                  dim_d = dim_q + DIM_W'(1);
               end
            end
         end
         STREAM: begin
            s_ready = bus.start && !bus.reload && (!m_valid_q || bus.m_ready);
            if (bus.s_valid && s_ready) begin
               stream_acc = 1'b1;
               dim_d      = last_dim ? '0 : dim_q + DIM_W'(1);
            end else if (!bus.start && (!m_valid_q || bus.m_ready)) begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
      if (out_fire) m_valid_d = 1'b0;
      if (stream_acc) begin
         m_valid_d = 1'b1;
         m_data_d  = bus.s_data;
         m_ref_d   = ref_rd;
         m_last_d  = last_dim;
      end
      if (bus.reload) begin
         state_d  = LOAD;
         dim_d    = '0;
         ref_d    = '0;
         loaded_d = 1'b0;
      end
   end

   // State and output registers; reset aborts everything including a pending beat.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= IDLE;
         dim_q     <= '0;
         ref_q     <= '0;
         loaded_q  <= 1'b0;
         m_valid_q <= 1'b0;
         m_data_q  <= '0;
         m_ref_q   <= '0;
         m_last_q  <= 1'b0;
      end else begin
         state_q   <= state_d;
         dim_q     <= dim_d;
         ref_q     <= ref_d;
         loaded_q  <= loaded_d;
         m_valid_q <= m_valid_d;
         m_data_q  <= m_data_d;
         m_ref_q   <= m_ref_d;
         m_last_q  <= m_last_d;
      end
   end

`ifdef REFBUF_VEC_COUNT_EN
   logic [31:0] vec_cnt_q;

   // Completed-vector counter: counts delivered last beats, cleared by reload.
   always_ff @(posedge clk) begin
      if (rst || bus.reload) vec_cnt_q <= '0;
      else if (out_fire && m_last_q) vec_cnt_q <= vec_cnt_q + 32'd1;
   end

   assign bus.vec_count = vec_cnt_q;
`endif

   assign bus.s_ready    = s_ready;
   assign bus.m_valid    = m_valid_q;
   assign bus.m_data     = m_data_q;
   assign bus.m_ref_data = m_ref_q;
   assign bus.m_last     = m_last_q;
   assign bus.loaded     = loaded_q;
endmodule

// File: tb/tb_ref_point_buffer.sv
// Directed bench for ref_point_buffer (DATA_WIDTH=8, DIMENSIONS=4, NUM_REFS=2).
module tb_ref_point_buffer;
   localparam int DW = 8;
   localparam int DIM = 4;
   localparam int NR = 2;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   total = 0;
   int   bad = 0;

   always #5 clk = ~clk;

   ref_point_buffer_if #(.DATA_WIDTH(DW), .NUM_REFS(NR)) bus_if ();

   ref_point_buffer #(
      .DATA_WIDTH (DW),
      .DIMENSIONS (DIM),
      .NUM_REFS   (NR)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus_if)
   );

   typedef struct {
      logic        st;
      logic        sv;
      logic [7:0]  d;
      logic        mr;
      logic        e_sr;
      logic        e_mv;
      logic [7:0]  e_md;
      logic [15:0] e_ref;
      logic        e_last;
   } row_t;

   row_t tbl[$];

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic void add(input logic st, input logic sv, input logic [7:0] d,
                               input logic mr, input logic e_sr, input logic e_mv,
                               input logic [7:0] e_md, input logic [15:0] e_ref,
                               input logic e_last);
      row_t r;
      r.st = st; r.sv = sv; r.d = d; r.mr = mr; r.e_sr = e_sr; r.e_mv = e_mv;
      r.e_md = e_md; r.e_ref = e_ref; r.e_last = e_last;
      tbl.push_back(r);
   endfunction

   // Loads eight reference elements base..base+7 (ref0 gets the first four).
   task automatic load8(input logic [7:0] base, input string nm);
      for (int i = 0; i < 8; i++) begin
         bus_if.s_valid = 1'b1;
         bus_if.s_data  = base + 8'(i);
         #1;
         chk({nm, "_sready"}, 32'(bus_if.s_ready), 32'd1);
         tick();
         chk({nm, "_loaded"}, 32'(bus_if.loaded), (i == 7) ? 32'd1 : 32'd0);
      end
      bus_if.s_valid = 1'b0;
   endtask

   initial begin
      bus_if.start   = 1'b0;
      bus_if.reload  = 1'b0;
      bus_if.s_valid = 1'b0;
      bus_if.s_data  = '0;
      bus_if.m_ready = 1'b1;

      // stream phase, backpressure, start drop (loaded=1 throughout)
      add(1,1,8'd10,1, 1,1,8'd10,16'h0501,0);
      add(1,1,8'd11,1, 1,1,8'd11,16'h0602,0);
      add(1,1,8'd12,1, 1,1,8'd12,16'h0703,0);
      add(1,1,8'd13,1, 1,1,8'd13,16'h0804,1);
      add(1,0,8'd0 ,1, 1,0,8'd13,16'h0804,1);
      add(1,1,8'd20,1, 1,1,8'd20,16'h0501,0);
      add(1,1,8'd21,0, 0,1,8'd20,16'h0501,0);
      add(1,1,8'd21,0, 0,1,8'd20,16'h0501,0);
      add(1,1,8'd21,0, 0,1,8'd20,16'h0501,0);
      add(1,1,8'd21,1, 1,1,8'd21,16'h0602,0);
      add(1,1,8'd22,1, 1,1,8'd22,16'h0703,0);
      add(1,1,8'd23,1, 1,1,8'd23,16'h0804,1);
      add(1,0,8'd0 ,1, 1,0,8'd23,16'h0804,1);
      add(1,1,8'd30,1, 1,1,8'd30,16'h0501,0);
      add(1,1,8'd31,1, 1,1,8'd31,16'h0602,0);
      add(0,1,8'd99,1, 0,0,8'd31,16'h0602,0);
      add(0,0,8'd0 ,1, 0,0,8'd31,16'h0602,0);
      add(1,1,8'd32,1, 0,0,8'd31,16'h0602,0);
      add(1,1,8'd32,1, 1,1,8'd32,16'h0703,0);
      add(1,1,8'd33,1, 1,1,8'd33,16'h0804,1);
      add(1,0,8'd0 ,1, 1,0,8'd33,16'h0804,1);

      // reset state
      tick(); tick();
      rst = 1'b0;
      #1;
      chk("rst_mvalid", 32'(bus_if.m_valid), 32'd0);
      chk("rst_mdata", 32'(bus_if.m_data), 32'd0);
      chk("rst_mref", 32'(bus_if.m_ref_data), 32'd0);
      chk("rst_mlast", 32'(bus_if.m_last), 32'd0);
      chk("rst_loaded", 32'(bus_if.loaded), 32'd0);
      chk("rst_sready", 32'(bus_if.s_ready), 32'd0);
`ifdef REFBUF_VEC_COUNT_EN
      chk("rst_vcount", bus_if.vec_count, 32'd0);
`endif

      // IDLE -> LOAD, then load 1..8 with start dropped for two beats
      bus_if.start = 1'b1;
      #1;
      chk("idle_sready", 32'(bus_if.s_ready), 32'd0);
      tick();
      for (int i = 0; i < 8; i++) begin
         bus_if.start   = (i == 2 || i == 3) ? 1'b0 : 1'b1;
         bus_if.s_valid = 1'b1;
         bus_if.s_data  = 8'(i + 1);
         #1;
         chk("load_sready", 32'(bus_if.s_ready), 32'd1);
         tick();
         chk("load_loaded", 32'(bus_if.loaded), (i == 7) ? 32'd1 : 32'd0);
         chk("load_mvalid", 32'(bus_if.m_valid), 32'd0);
      end

      // table-driven streaming
      foreach (tbl[k]) begin
         bus_if.start   = tbl[k].st;
         bus_if.s_valid = tbl[k].sv;
         bus_if.s_data  = tbl[k].d;
         bus_if.m_ready = tbl[k].mr;
         #1;
         chk($sformatf("row%0d_sready", k), 32'(bus_if.s_ready), 32'(tbl[k].e_sr));
         tick();
         chk($sformatf("row%0d_mvalid", k), 32'(bus_if.m_valid), 32'(tbl[k].e_mv));
         chk($sformatf("row%0d_mdata", k), 32'(bus_if.m_data), 32'(tbl[k].e_md));
         chk($sformatf("row%0d_mref", k), 32'(bus_if.m_ref_data), 32'(tbl[k].e_ref));
         chk($sformatf("row%0d_mlast", k), 32'(bus_if.m_last), 32'(tbl[k].e_last));
         chk($sformatf("row%0d_loaded", k), 32'(bus_if.loaded), 32'd1);
      end
`ifdef REFBUF_VEC_COUNT_EN
      chk("vcount_3", bus_if.vec_count, 32'd3);
`endif

      // reload coincident with s_valid while a beat is pending
      bus_if.start = 1'b1; bus_if.s_valid = 1'b1; bus_if.s_data = 8'd40; bus_if.m_ready = 1'b0;
      tick();
      chk("pend_mdata", 32'(bus_if.m_data), 32'd40);
      bus_if.s_data = 8'd50; bus_if.reload = 1'b1;
      #1;
      chk("reload_sready", 32'(bus_if.s_ready), 32'd0);
      tick();
      bus_if.reload = 1'b0; bus_if.s_valid = 1'b0;
      chk("reload_loaded", 32'(bus_if.loaded), 32'd0);
      chk("reload_mvalid", 32'(bus_if.m_valid), 32'd1);
      chk("reload_mdata", 32'(bus_if.m_data), 32'd40);
      chk("reload_mref", 32'(bus_if.m_ref_data), 32'h0501);
`ifdef REFBUF_VEC_COUNT_EN
      chk("reload_vcount", bus_if.vec_count, 32'd0);
`endif
      bus_if.m_ready = 1'b1;
      load8(8'd20, "reload");
      chk("reload_drained", 32'(bus_if.m_valid), 32'd0);

      // stream with the new references
      for (int k = 0; k < 4; k++) begin
         bus_if.s_valid = 1'b1;
         bus_if.s_data  = 8'(60 + k);
         tick();
         chk("new_mdata", 32'(bus_if.m_data), 32'(60 + k));
         chk("new_mref", 32'(bus_if.m_ref_data), {16'h0, 8'(24 + k), 8'(20 + k)});
         chk("new_mlast", 32'(bus_if.m_last), (k == 3) ? 32'd1 : 32'd0);
      end
      bus_if.s_valid = 1'b0;
      tick();
      chk("new_drain", 32'(bus_if.m_valid), 32'd0);
`ifdef REFBUF_VEC_COUNT_EN
      chk("new_vcount", bus_if.vec_count, 32'd1);
`endif

      // reset with a pending beat and a partial load
      bus_if.s_valid = 1'b1; bus_if.s_data = 8'd70; bus_if.m_ready = 1'b0;
      tick();
      chk("pre_rst_mref", 32'(bus_if.m_ref_data), 32'h1814);
      bus_if.s_valid = 1'b0; bus_if.reload = 1'b1;
      tick();
      bus_if.reload = 1'b0;
      bus_if.s_valid = 1'b1; bus_if.s_data = 8'd1;
      tick();
      bus_if.s_data = 8'd2;
      tick();
      chk("midload_mvalid", 32'(bus_if.m_valid), 32'd1);
      bus_if.s_valid = 1'b0;
      rst = 1'b1;
      tick();
      chk("rst2_mvalid", 32'(bus_if.m_valid), 32'd0);
      chk("rst2_mdata", 32'(bus_if.m_data), 32'd0);
      chk("rst2_mref", 32'(bus_if.m_ref_data), 32'd0);
      chk("rst2_mlast", 32'(bus_if.m_last), 32'd0);
      chk("rst2_loaded", 32'(bus_if.loaded), 32'd0);
      chk("rst2_sready", 32'(bus_if.s_ready), 32'd0);
      rst = 1'b0; bus_if.m_ready = 1'b1;
      tick();
      load8(8'd1, "reload2");
      bus_if.s_valid = 1'b1; bus_if.s_data = 8'd80;
      tick();
      bus_if.s_valid = 1'b0;
      chk("post_rst_mdata", 32'(bus_if.m_data), 32'd80);
      chk("post_rst_mref", 32'(bus_if.m_ref_data), 32'h0501);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/ref_point_buffer.md
Name: ref_point_buffer

Overview:
- Next-generation reference-point buffer for the KNN accelerator. Loads NUM_REFS reference vectors of DIMENSIONS elements each.
- Then streams incoming data-point elements to the distance units. Each streamed element is paired, in parallel, with the matching dimension element of every reference.
- Uses valid/ready handshakes on both sides and supports reload of references without reset.

Parameters:
- DATA_WIDTH, 32, width of one vector element
- DIMENSIONS, 32, elements per vector (>=2)
- NUM_REFS, 4, reference vectors held and emitted in parallel (>=1)

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- start  in  1  level enable; low halts intake
- reload  in  1  single-cycle pulse; discard references and reload
- s_valid  in  1  input element valid
- s_data  in  DATA_WIDTH  input element (reference during load, data point during stream)
- s_ready  out  1  input element accepted when s_valid && s_ready
- m_valid  out  1  output beat valid
- m_ready  in  1  downstream accepts beat
- m_data  out  DATA_WIDTH  data-point element
- m_ref_data  out  NUM_REFS*DATA_WIDTH  reference r element at bits [r*DATA_WIDTH +: DATA_WIDTH]
- m_last  out  1  beat is final dimension of a data vector
- loaded  out  1  all references loaded

Behaviour:
- Reset:
  - state IDLE; m_valid=0, m_data=0, m_ref_data=0, m_last=0, loaded=0.
  - dim_idx=0, ref_idx=0, all reference storage cleared to 0.
  - Reset mid-operation aborts everything, including a pending output beat.
- FSM states: IDLE, LOAD, STREAM.
- IDLE:
  - s_ready=0.
  - start && !loaded -> LOAD.
  - start && loaded -> STREAM.
- LOAD:
  - s_ready=1, except in a reload cycle.
  - Each accepted beat writes ref[ref_idx][dim_idx], then dim_idx increments.
  - At dim_idx==DIMENSIONS-1, dim_idx wraps to 0 and ref_idx increments.
  - On the write of ref NUM_REFS-1, dim DIMENSIONS-1: loaded<=1, ref_idx<=0, next state STREAM.
  - start low does not stall LOAD.
- STREAM:
  - s_ready = start && !reload && (!m_valid || m_ready).
  - Accepted beat registers: m_data<=s_data; m_ref_data<=all refs at dim_idx; m_last<=(dim_idx==DIMENSIONS-1); m_valid<=1.
  - Latency is 1 cycle. Full throughput (1 beat/cycle) when m_ready is held high.
  - dim_idx wraps DIMENSIONS-1 -> 0 after each data vector.
- Output register:
  - m_valid clears on m_valid && m_ready with no new accept.
  - Output fields hold stable while m_valid && !m_ready.
- start low in STREAM:
  - No new accepts.
  - Once m_valid==0 (or is being cleared this cycle) -> IDLE.
  - dim_idx is preserved, so a partial vector resumes.
- reload (any state except during reset):
  - Next state LOAD; dim_idx=0, ref_idx=0, loaded=0.
  - reload wins over a same-cycle s_valid: that beat is not accepted.
  - A pending output beat is retained and drains normally; its m_ref_data is already registered.
  - reload during LOAD restarts the load from ref 0, dim 0.
- Width rules:
  - dim_idx is $clog2(DIMENSIONS) bits; ref_idx is $clog2(NUM_REFS) bits, minimum 1.
  - No arithmetic on data; elements pass bit-exact.

Optional Feature:
- Macro: REFBUF_VEC_COUNT_EN.
- Defined: adds output vec_count (32 bits).
  - Increments on every m_valid && m_ready && m_last; wraps at 2^32.
  - Resets to 0 and clears on reload.
- Undefined: port and counter absent; all other behaviour identical.

Decomposition:
- Package knn_pkg:
  - state typedef (IDLE, LOAD, STREAM).
  - Localparam helpers for dim_idx and ref_idx widths (clog2, minimum 1).
- Sub-module ref_bank:
  - One reference vector, DIMENSIONS x DATA_WIDTH registers.
  - Synchronous write port (we, waddr, wdata); combinational read at raddr; synchronous clear on rst.
  - Instantiated NUM_REFS times via generate; we = load accept && (ref_idx==r).

Test Plan (DATA_WIDTH=8, DIMENSIONS=4, NUM_REFS=2):
- Reset then start=1; feed 1..8 with s_valid held -> loaded=1 after 8th beat; ref0={1,2,3,4}, ref1={5,6,7,8}; state STREAM.
- Stream 10,11,12,13 with m_ready=1 -> beats 1 cycle later:
  - m_data=10..13
  - m_ref_data lanes (1,5),(2,6),(3,7),(4,8)
  - m_last only on 13
- Backpressure: m_ready=0 for 3 cycles mid-vector -> s_ready=0, output beat held stable, no beat lost or duplicated; resume completes the vector in order.
- Drop start after 2 elements, then restore it -> IDLE entered after drain; next two beats paired with dims 2,3, m_last on the second.
- reload pulse coincident with s_valid in STREAM -> beat not accepted; loaded=0; reload 20..27 -> ref0={20..23}, subsequent streaming uses new values.
- rst asserted with m_valid=1 and mid-load -> next cycle all outputs 0, state IDLE; with REFBUF_VEC_COUNT_EN, vec_count=0, and after 3 full vectors reads 3.
